// File: rtl/hazard_scoreboard_if.sv
// Decode/issue, writeback and drain signals shared between the decode stage
// and the hazard scoreboard.
interface hazard_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_rs1_used;
  logic        id_rs2_used;
  logic [4:0]  id_rd;
  logic        id_rd_wr;
  logic        id_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        drain_req;
  logic        drain_done;
  logic        busy;
  logic [31:0] stall_cnt;
  logic        err;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wr,
    output wb_valid, wb_rd, drain_req,
    input  id_ready, drain_done, busy, stall_cnt, err
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_rd_wr,
    input  wb_valid, wb_rd, drain_req,
    output id_ready, drain_done, busy, stall_cnt, err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register in-flight write counters gate issue
// on RAW and counter-overflow hazards, with a drain handshake and stall counter.
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [31:0]      STALL_MAX = 32'hFFFF_FFFF;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NREG];
  logic [CNT_W-1:0]  cnt_d [NREG];
  logic              err_q, err_d;
  logic [31:0]       stall_q, stall_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  rs1_cnt_s, rs2_cnt_s, rd_cnt_s, wb_cnt_s;
  logic              id_ready_s;
  logic              issue_s;
  logic              inc_s, dec_s;
  logic              zero_d_s;

  function automatic logic hit(input logic en, input logic [4:0] idx, input int r);
    return en && (int'(idx) == r);
  endfunction

  // Count lookups; index 0 and out-of-range indices read as zero
  always_comb begin
    rs1_cnt_s = '0;
    rs2_cnt_s = '0;
    rd_cnt_s  = '0;
    wb_cnt_s  = '0;
    for (int r = 1; r < NREG; r++) begin
      rs1_cnt_s |= hit(1'b1, bus.id_rs1, r) ? cnt_q[r] : '0;
      rs2_cnt_s |= hit(1'b1, bus.id_rs2, r) ? cnt_q[r] : '0;
      rd_cnt_s  |= hit(1'b1, bus.id_rd,  r) ? cnt_q[r] : '0;
      wb_cnt_s  |= hit(1'b1, bus.wb_rd,  r) ? cnt_q[r] : '0;
    end
  end

  // Issue gate uses registered counts only, so a same-cycle writeback never bypasses it
  always_comb begin
    id_ready_s = (state_q == S_RUN)
               && !(bus.id_rs1_used && (rs1_cnt_s != '0))
               && !(bus.id_rs2_used && (rs2_cnt_s != '0))
               && !(bus.id_rd_wr    && (rd_cnt_s  == CNT_MAX));
    issue_s    = bus.id_valid && id_ready_s;
  end

  // Counter, error and stall next-state
  always_comb begin
    inc_s    = 1'b0;
    dec_s    = 1'b0;
    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      inc_s = hit(issue_s && bus.id_rd_wr, bus.id_rd, r);
      dec_s = hit(bus.wb_valid, bus.wb_rd, r);
      if (inc_s && !dec_s) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec_s && !inc_s && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end else begin
        cnt_d[r] = cnt_q[r];
      end
    end

    zero_d_s = 1'b1;
    for (int r = 0; r < NREG; r++) begin
      zero_d_s &= (cnt_d[r] == '0);
    end
    busy_d = !zero_d_s;

    err_d = err_q | (bus.wb_valid && (bus.wb_rd != 5'd0) && (wb_cnt_s == '0));

    if ((state_q == S_RUN) && bus.id_valid && !id_ready_s && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Drain FSM: DRAIN waits on the post-update counts, so DONE follows the last writeback
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (bus.drain_req) state_d = S_DRAIN;
        else               state_d = S_RUN;
      end
      S_DRAIN: begin
        if (zero_d_s) state_d = S_DONE;
        else          state_d = S_DRAIN;
      end
      S_DONE: begin
        if (!bus.drain_req) state_d = S_RUN;
        else                state_d = S_DONE;
      end
      default: state_d = S_RUN;
    endcase
    done_d = (state_d == S_DONE);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      err_q   <= 1'b0;
      stall_q <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign bus.id_ready   = id_ready_s;
  assign bus.busy       = busy_q;
  assign bus.drain_done = done_q;
  assign bus.stall_cnt  = stall_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: driver pushes reference-model expectations per cycle,
// a monitor pops and compares them against the DUT on the falling edge.
module tb_hazard_scoreboard;
  localparam int NREG = 32;
  localparam int MAXC = 3;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if bus();
  hazard_scoreboard #(.NREG(NREG), .CNT_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string  tag;
    bit     ready, busy, done, err;
    longint stall;
    int     w_ready, w_busy, w_done, w_err;
    longint w_stall;
  } exp_t;

  exp_t   q[$];
  int     vectors = 0, miscompares = 0, checks = 0;

  // reference model
  int     m_cnt[NREG];
  int     m_mode;
  bit     m_err;
  longint m_stall;

  // directed expectations for the next cycle (-1 = none)
  int     w_ready = -1, w_busy = -1, w_done = -1, w_err = -1;
  longint w_stall = -1;

  task automatic clear_model();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_mode = M_RUN; m_err = 1'b0; m_stall = 0;
  endtask

  task automatic cyc(input string tag, input bit r, input bit v,
                     input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit wr, input bit wb, input int wbrd, input bit dr);
    exp_t e;
    bit rdy, issue, any, allz;
    @(posedge clk); #1;
    rst = r; bus.id_valid = v; bus.id_rs1 = 5'(rs1); bus.id_rs1_used = u1;
    bus.id_rs2 = 5'(rs2); bus.id_rs2_used = u2; bus.id_rd = 5'(rd); bus.id_rd_wr = wr;
    bus.wb_valid = wb; bus.wb_rd = 5'(wbrd); bus.drain_req = dr;

    rdy = (m_mode == M_RUN) && !(u1 && m_cnt[rs1] > 0) && !(u2 && m_cnt[rs2] > 0)
          && !(wr && m_cnt[rd] == MAXC);
    any = 1'b0;
    foreach (m_cnt[i]) if (m_cnt[i] > 0) any = 1'b1;
    e.tag = tag; e.ready = rdy; e.busy = any; e.done = (m_mode == M_DONE);
    e.err = m_err; e.stall = m_stall;
    e.w_ready = w_ready; e.w_busy = w_busy; e.w_done = w_done; e.w_err = w_err;
    e.w_stall = w_stall;
    q.push_back(e);
    w_ready = -1; w_busy = -1; w_done = -1; w_err = -1; w_stall = -1;

    // advance model across the coming edge
    if (r) begin
      clear_model();
    end else begin
      issue = v && rdy;
      if (m_mode == M_RUN && v && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (wb && wbrd != 0 && m_cnt[wbrd] == 0) m_err = 1'b1;
      if (!(issue && wr && rd != 0 && wb && wbrd == rd)) begin
        if (issue && wr && rd != 0) m_cnt[rd]++;
        if (wb && wbrd != 0 && m_cnt[wbrd] > 0) m_cnt[wbrd]--;
      end
      allz = 1'b1;
      foreach (m_cnt[i]) if (m_cnt[i] > 0) allz = 1'b0;
      if (m_mode == M_RUN && dr) m_mode = M_DRAIN;
      else if (m_mode == M_DRAIN && allz) m_mode = M_DONE;
      else if (m_mode == M_DONE && !dr) m_mode = M_RUN;
    end
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string tag, input string what, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s %s: got %0d want %0d", tag, what, act, exp);
    end
  endtask

  // monitor: compare one expectation per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        chk(e.tag, "id_ready",   bus.id_ready,   e.ready);
        chk(e.tag, "busy",       bus.busy,       e.busy);
        chk(e.tag, "drain_done", bus.drain_done, e.done);
        chk(e.tag, "err",        bus.err,        e.err);
        chk(e.tag, "stall_cnt",  bus.stall_cnt,  e.stall);
        if (e.w_ready >= 0) chk(e.tag, "id_ready(dir)",   bus.id_ready,   e.w_ready);
        if (e.w_busy  >= 0) chk(e.tag, "busy(dir)",       bus.busy,       e.w_busy);
        if (e.w_done  >= 0) chk(e.tag, "drain_done(dir)", bus.drain_done, e.w_done);
        if (e.w_err   >= 0) chk(e.tag, "err(dir)",        bus.err,        e.w_err);
        if (e.w_stall >= 0) chk(e.tag, "stall_cnt(dir)",  bus.stall_cnt,  e.w_stall);
      end
    end
  end

  initial begin
    bit dr;
    int wbrd, pend[$];
    bit wb;
    rst = 1'b1; bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rs1_used = 0;
    bus.id_rs2_used = 0; bus.id_rd = 0; bus.id_rd_wr = 0; bus.wb_valid = 0; bus.wb_rd = 0;
    bus.drain_req = 0;
    repeat (2) @(posedge clk);
    clear_model();

    // post-reset state, any instruction may issue
    w_ready = 1; w_busy = 0; w_done = 0; w_err = 0; w_stall = 0;
    cyc("reset", 0, 1, 3, 1, 4, 1, 5, 1, 0, 0, 0);
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // RAW stall on x5
    w_ready = 1; cyc("raw1", 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    w_ready = 0; cyc("raw2", 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    w_ready = 0; cyc("raw3", 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    w_ready = 0; cyc("raw4", 0, 1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    w_ready = 1; w_stall = 3; cyc("raw5", 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // WAW saturation on x7
    for (int i = 0; i < 3; i++) begin
      w_ready = 1; cyc("waw_issue", 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    end
    w_ready = 0; w_busy = 1; cyc("waw_full", 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    w_ready = 0; cyc("waw_wb", 0, 1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    w_ready = 1; cyc("waw_resume", 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // simultaneous issue and writeback on x3
    w_ready = 1; cyc("sim_issue", 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    w_ready = 1; cyc("sim_both", 0, 1, 0, 0, 0, 0, 3, 1, 1, 3, 0);
    w_ready = 0; w_busy = 1; w_err = 0; cyc("sim_after", 0, 1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
    w_busy = 0; w_err = 0; idle("sim_empty");
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // x0 writes and the error path
    w_ready = 1; cyc("x0_issue", 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    w_busy = 0; w_err = 0; cyc("x0_wb", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    w_busy = 0; w_err = 0; cyc("x9_wb", 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    w_err = 1; w_busy = 0; idle("err_set");
    w_err = 1; idle("err_sticky");
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // drain with two pending writes
    cyc("dr_i4", 0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    cyc("dr_i6", 0, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    w_ready = 1; cyc("dr_req", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    w_ready = 0; w_done = 0; cyc("dr_blk", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    w_ready = 0; cyc("dr_wb4", 0, 1, 0, 0, 0, 0, 0, 0, 1, 4, 1);
    w_done = 0; cyc("dr_wb6", 0, 1, 0, 0, 0, 0, 0, 0, 1, 6, 1);
    w_done = 1; w_ready = 0; w_busy = 0; cyc("dr_done", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    w_done = 0; w_ready = 1; cyc("dr_run", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset while draining
    cyc("rd_i4a", 0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    cyc("rd_i4b", 0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    cyc("rd_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    w_ready = 0; w_busy = 1; cyc("rd_rst", 1, 1, 0, 0, 0, 0, 4, 1, 0, 0, 1);
    w_ready = 1; w_busy = 0; w_done = 0; cyc("rd_after", 0, 1, 4, 1, 0, 0, 4, 1, 0, 0, 0);

    // randomized traffic against the model
    dr = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) dr = ~dr;
      pend.delete();
      for (int i = 1; i < NREG; i++) if (m_cnt[i] > 0) pend.push_back(i);
      wb = 1'b0; wbrd = 0;
      if ($urandom_range(0, 99) < 2) begin
        wb = 1'b1; wbrd = $urandom_range(0, 9);
      end else if (pend.size() > 0 && $urandom_range(0, 9) < 4) begin
        wb = 1'b1; wbrd = pend[$urandom_range(0, pend.size() - 1)];
      end
      cyc("rand", ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
          $urandom_range(0, 9), $urandom_range(0, 1), $urandom_range(0, 9), $urandom_range(0, 1),
          $urandom_range(0, 9), $urandom_range(0, 1), wb, wbrd, dr);
    end
    idle("tail");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NREG, default 32, giving the number of architectural registers tracked; index 0 is hardwired zero.
REQ-002 The block SHALL have parameter CNT_W, default 2, giving the per-register in-flight write counter width; the maximum count is 2^CNT_W-1.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-005 The block SHALL have port id_valid, input, 1, decode holds an instruction requesting issue.
REQ-006 The block SHALL have ports id_rs1 and id_rs2, input, 5 each, the source register indices.
REQ-007 The block SHALL have ports id_rs1_used and id_rs2_used, input, 1 each, asserted when the corresponding source is actually read.
REQ-008 The block SHALL have port id_rd, input, 5, the destination register index, and port id_rd_wr, input, 1, asserted when the instruction writes id_rd.
REQ-009 The block SHALL have port id_ready, output, 1, issue permitted this cycle; an issue occurs when id_valid and id_ready are both 1.
REQ-010 The block SHALL have ports wb_valid, input, 1, and wb_rd, input, 5, a register-file write (RUWr) retiring to wb_rd.
REQ-011 The block SHALL have ports drain_req, input, 1, and drain_done, output, 1, the drain handshake.
REQ-012 The block SHALL have port busy, output, 1, asserted when any counter is non-zero.
REQ-013 The block SHALL have port stall_cnt, output, 32, cycles stalled on a hazard.
REQ-014 The block SHALL have port err, output, 1, a sticky protocol-error flag.

Function
REQ-015 The block SHALL keep a counter cnt[r] of CNT_W bits for r = 1..NREG-1; cnt[0] SHALL read as 0 at all times.
REQ-016 An issue with id_rd_wr=1 and id_rd!=0 SHALL increment cnt[id_rd]; a wb_valid with wb_rd!=0 SHALL decrement cnt[wb_rd].
REQ-017 When an issue and a writeback target the same register in the same cycle, that register's count SHALL be left unchanged.
REQ-018 A writeback to a register whose count is 0 SHALL leave the count at 0 and set err to 1 until reset.
REQ-019 id_ready SHALL be 0 whenever any of the following holds; otherwise it SHALL be 1:
  - state is not RUN;
  - id_rs1_used=1 and cnt[id_rs1]!=0;
  - id_rs2_used=1 and cnt[id_rs2]!=0;
  - id_rd_wr=1 and cnt[id_rd] is at maximum (prevents counter overflow).
REQ-020 id_ready SHALL be computed only from registered counts; a same-cycle writeback SHALL NOT bypass it, so issue resumes one cycle after the clearing writeback.
REQ-021 id_ready SHALL be combinational from the decode inputs and registered state, with zero-cycle latency.
REQ-022 The FSM SHALL have three states, with the following transitions:
  - RUN -> DRAIN when drain_req=1;
  - DRAIN -> DONE when all counters are 0 (evaluated on the registered counts after that cycle's updates);
  - DONE -> RUN when drain_req=0.
REQ-023 drain_done SHALL be 1 exactly in the DONE state.
REQ-024 If drain_req is deasserted while in DRAIN, the FSM SHALL still complete the sequence through DONE and then return to RUN.
REQ-025 Writebacks SHALL be accepted in every state.
REQ-026 stall_cnt SHALL increment by 1 in each cycle with state RUN, id_valid=1 and id_ready=0, and SHALL saturate at 0xFFFFFFFF.
REQ-027 busy SHALL be registered-state derived, with no dependency on the current cycle's inputs.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL clear all counters, set the state to RUN, and clear err and stall_cnt to 0; issue and writeback inputs in that cycle SHALL be ignored.
REQ-029 After reset the outputs SHALL be: busy=0, drain_done=0, stall_cnt=0, err=0, and id_ready=1 for any instruction.
REQ-030 A reset asserted in any state, including mid-drain, SHALL take effect at the next edge with no residual state.

Verification
REQ-031 The bench SHALL cover a RAW stall:
  - stimulus: issue rd=5; next cycle id_valid with rs1=5, rs1_used=1; wb_rd=5 on cycle 4;
  - required response: id_ready=0 on cycles 2-4, id_ready=1 on cycle 5, stall_cnt=3.
REQ-032 The bench SHALL cover WAW saturation (CNT_W=2):
  - stimulus: three issues with rd=7 and no writeback, then a fourth rd=7 request;
  - required response: the fourth sees id_ready=0; after one wb_rd=7 it issues.
REQ-033 The bench SHALL cover simultaneous issue and writeback:
  - stimulus: cnt[3]=1; in one cycle issue rd=3 and wb_rd=3;
  - required response: cnt[3] stays 1, busy=1, err=0.
REQ-034 The bench SHALL cover x0 and the error path:
  - stimulus: issue rd=0; then wb_rd=0; then wb_rd=9 with cnt[9]=0;
  - required response: busy stays 0; err=1 only after the wb_rd=9 writeback, and it stays 1.
REQ-035 The bench SHALL cover drain:
  - stimulus: two pending writes (rd=4 and rd=6); assert drain_req; retire both writebacks;
  - required response: id_ready=0 from the cycle after drain_req; drain_done=1 the cycle after the last writeback; RUN is re-entered after drain_req drops.
REQ-036 The bench SHALL cover reset mid-drain:
  - stimulus: assert rst for one cycle while in DRAIN with cnt[4]=2;
  - required response: busy=0, drain_done=0, id_ready=1 on the next cycle.
